commit_scheduler: RTL and testbench
===================================

# commit_scheduler

In-order retirement controller between the ROB head and the architectural register file. Each cycle it decides whether the ROB head entry may retire. It drives the register file's commit write port (valid/index/rd/value) and sequences store retirement through a handshake with the load/store buffer. On a mispredicted control-flow instruction it raises the single-cycle global flush with the redirect PC.

## Interface
- ROB_IDX_W, 6, ROB index width; matches register-file rename tag width

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; when 0 all state, counters and outputs hold
- head_valid  in  1  ROB non-empty; head fields meaningful
- head_ready  in  1  head result complete
- head_index  in  ROB_IDX_W  ROB slot of head
- head_type  in  2  00 reg-writing op, 01 store, 10 branch, 11 jal/jalr (writes rd)
- head_rd  in  5  destination register
- head_value  in  32  result value
- head_mispredict  in  1  control-flow head was mispredicted
- head_target  in  32  correct next PC
- pop  out  1  dequeue ROB head (one-cycle pulse)
- rf_valid  out  1  register-file commit write strobe
- rf_index  out  ROB_IDX_W  tag of committing entry
- rf_rd  out  5  destination register
- rf_value  out  32  committed value
- st_commit  out  1  store at head may write memory (pulse)
- st_index  out  ROB_IDX_W  ROB tag of that store
- st_done  in  1  LSB finished the committed store
- flush  out  1  global pipeline flush (pulse)
- redirect_pc  out  32  fetch redirect, valid with flush
- commit_cnt  out  32  retired-instruction count

## Operation
- All outputs registered. Reset value of every output, including commit_cnt and redirect_pc, is 0. State resets to IDLE.
- States: IDLE, COMMIT, WAIT_ST, FLUSH. Pulse outputs are 0 unless stated below.
- IDLE, when head_valid && head_ready:
  - type 00 or 11: next state COMMIT. Outputs: pop=1; rf_valid=(head_rd!=0); rf_index/rf_rd/rf_value taken from the head.
  - type 10: next state COMMIT with pop=1, rf_valid=0.
  - type 01: next state WAIT_ST. Outputs: st_commit=1, st_index=head_index, pop=0.
  - A mispredict flag is latched on type 10/11 when head_mispredict=1; head_target is latched with it.
- IDLE, when head not valid or not ready: hold IDLE.
- COMMIT: the head is ignored, because the ROB pointer is still advancing.
  - Latched mispredict: go to FLUSH with flush=1, redirect_pc=latched target.
  - Otherwise: return to IDLE.
- WAIT_ST: st_done is sampled only in this state. When st_done=1, go to COMMIT with pop=1, and the store is treated as a non-mispredicted op. Otherwise hold WAIT_ST with no timeout.
- FLUSH: flush lasts exactly one cycle. Clear the mispredict latch, then go to IDLE. The head is ignored.
- commit_cnt increments by 1 on every cycle pop is driven high, and wraps modulo 2^32.
- An rd write and a flush never share a cycle. The register file drops writes on flush, so a mispredicted jal/jalr commits rd first and flushes the following cycle.

## Timing
- A head sampled at edge N produces pop/rf_* high in cycle N+1, for one cycle only.
- Peak throughput is one retirement per 2 cycles, because of the mandatory COMMIT bubble.
- Mispredict sequence: pop/rf write at N+1, flush at N+2, back in IDLE at N+3.
- Store sequence: st_commit at N+1; st_done sampled from edge N+2 onward; pop the cycle after st_done is seen.
- rdy=0 in any state freezes state, latch, counter and outputs. A pulse held high across an rdy-low stretch is legal, because downstream blocks are also frozen by rdy.
- rst asserted in any state, including WAIT_ST or FLUSH, returns to IDLE with all outputs 0 at the next edge. A pending store is abandoned.

## Test plan
- After reset, with head_valid=0 for 5 cycles: all outputs 0, commit_cnt=0.
- Head type 00, rd=5, value=0x1234, index=3: exactly one cycle with pop=1, rf_valid=1, rf_rd=5, rf_value=0x1234, rf_index=3; commit_cnt=1. Same entry with rd=0: pop=1, rf_valid=0.
- Store at index 7: st_commit=1 with st_index=7. st_done held 0 for 4 cycles: no pop. Then st_done=1: pop one cycle later.
- Mispredicted jalr, rd=1, target=0x80: cycle A has rf_valid=1 with rf_rd=1 and pop=1. Cycle A+1 has flush=1, redirect_pc=0x80, rf_valid=0.
- Two back-to-back ready type-00 heads: pops two cycles apart, never adjacent; commit_cnt=2.
- rdy dropped while in COMMIT: pop stays high and commit_cnt unchanged until rdy returns. rst asserted in WAIT_ST: IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/commit_scheduler.sv
// In-order retirement controller: retires the ROB head into the register file,
// sequences store commits through the LSB handshake and raises flush on mispredicts.
module commit_scheduler #(
    parameter int ROB_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic [ROB_IDX_W-1:0] head_index,
    input  logic [1:0]           head_type,
    input  logic [4:0]           head_rd,
    input  logic [31:0]          head_value,
    input  logic                 head_mispredict,
    input  logic [31:0]          head_target,
    output logic                 pop,
    output logic                 rf_valid,
    output logic [ROB_IDX_W-1:0] rf_index,
    output logic [4:0]           rf_rd,
    output logic [31:0]          rf_value,
    output logic                 st_commit,
    output logic [ROB_IDX_W-1:0] st_index,
    input  logic                 st_done,
    output logic                 flush,
    output logic [31:0]          redirect_pc,
    output logic [31:0]          commit_cnt
);

    typedef enum logic [1:0] {IDLE, COMMIT, WAIT_ST, FLUSH} state_t;

    localparam logic [1:0] TYPE_STORE  = 2'b01;
    localparam logic [1:0] TYPE_BRANCH = 2'b10;

    state_t                 state_reg, state_next;
    logic                   mispredict_reg, mispredict_next;
    logic [31:0]            target_reg, target_next;
    logic                   pop_next, rf_valid_next, st_commit_next, flush_next;
    logic [ROB_IDX_W-1:0]   rf_index_next, st_index_next;
    logic [4:0]             rf_rd_next;
    logic [31:0]            rf_value_next, redirect_pc_next, commit_cnt_next;

    always_comb begin
        state_next       = state_reg;
        mispredict_next  = mispredict_reg;
        target_next      = target_reg;
        pop_next         = 1'b0;
        rf_valid_next    = 1'b0;
        st_commit_next   = 1'b0;
        flush_next       = 1'b0;
        rf_index_next    = rf_index;
        rf_rd_next       = rf_rd;
        rf_value_next    = rf_value;
        st_index_next    = st_index;
        redirect_pc_next = redirect_pc;
        commit_cnt_next  = commit_cnt;

        case (state_reg)
            IDLE: begin
                if (head_valid && head_ready) begin
                    if (head_type == TYPE_STORE) begin
                        state_next     = WAIT_ST;
                        st_commit_next = 1'b1;
                        st_index_next  = head_index;
                    end else begin
                        state_next = COMMIT;
                        pop_next   = 1'b1;
                        // Branches carry no destination; x0 writes are suppressed.
                        if (head_type != TYPE_BRANCH) begin
                            rf_valid_next = (head_rd != 5'd0);
                            rf_index_next = head_index;
                            rf_rd_next    = head_rd;
                            rf_value_next = head_value;
                        end
                        if (head_type[1] && head_mispredict) begin
                            mispredict_next = 1'b1;
                            target_next     = head_target;
                        end
                    end
                end
            end
            COMMIT: begin
                // The flush comes one cycle after the rd write so the RF keeps it.
                if (mispredict_reg) begin
                    state_next       = FLUSH;
                    flush_next       = 1'b1;
                    redirect_pc_next = target_reg;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_ST: begin
                if (st_done) begin
                    state_next = COMMIT;
                    pop_next   = 1'b1;
                end
            end
            FLUSH: begin
                mispredict_next = 1'b0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (pop_next)
            commit_cnt_next = commit_cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            mispredict_reg <= 1'b0;
            target_reg     <= '0;
            pop            <= 1'b0;
            rf_valid       <= 1'b0;
            rf_index       <= '0;
            rf_rd          <= '0;
            rf_value       <= '0;
            st_commit      <= 1'b0;
            st_index       <= '0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            commit_cnt     <= '0;
        end else if (rdy) begin
            state_reg      <= state_next;
            mispredict_reg <= mispredict_next;
            target_reg     <= target_next;
            pop            <= pop_next;
            rf_valid       <= rf_valid_next;
            rf_index       <= rf_index_next;
            rf_rd          <= rf_rd_next;
            rf_value       <= rf_value_next;
            st_commit      <= st_commit_next;
            st_index       <= st_index_next;
            flush          <= flush_next;
            redirect_pc    <= redirect_pc_next;
            commit_cnt     <= commit_cnt_next;
        end
    end

endmodule

// File: tb/tb_commit_scheduler.sv
// Scoreboard bench for commit_scheduler: the driver queues timed expected events,
// the monitor checks every cycle in which a pulse output is high.
module tb_commit_scheduler;

    logic        clk = 1'b0;
    logic        rst, rdy, head_valid, head_ready, head_mispredict, st_done;
    logic [5:0]  head_index;
    logic [1:0]  head_type;
    logic [4:0]  head_rd;
    logic [31:0] head_value, head_target;
    logic        pop, rf_valid, st_commit, flush;
    logic [5:0]  rf_index, st_index;
    logic [4:0]  rf_rd;
    logic [31:0] rf_value, redirect_pc, commit_cnt;

    commit_scheduler #(.ROB_IDX_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .head_valid(head_valid), .head_ready(head_ready), .head_index(head_index),
        .head_type(head_type), .head_rd(head_rd), .head_value(head_value),
        .head_mispredict(head_mispredict), .head_target(head_target),
        .pop(pop), .rf_valid(rf_valid), .rf_index(rf_index), .rf_rd(rf_rd),
        .rf_value(rf_value), .st_commit(st_commit), .st_index(st_index),
        .st_done(st_done), .flush(flush), .redirect_pc(redirect_pc),
        .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic        pop, rfv, st, fl;
        logic [5:0]  idx;
        logic [4:0]  rd;
        logic [31:0] val, pc, cnt;
    } exp_t;

    typedef struct {
        logic [1:0]  t;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [5:0]  idx;
        logic        mis;
        logic [31:0] tgt;
        logic        exp_rfv, exp_flush;
    } vec_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    logic [31:0] exp_cnt = 0;

    task automatic push_ev(input int unsigned c, input logic p, input logic rfv, input logic st,
                           input logic fl, input logic [5:0] idx, input logic [4:0] rd,
                           input logic [31:0] val, input logic [31:0] pc, input logic [31:0] cnt);
        exp_t e;
        e.cyc = c; e.pop = p; e.rfv = rfv; e.st = st; e.fl = fl;
        e.idx = idx; e.rd = rd; e.val = val; e.pc = pc; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({pop, rf_valid, rf_index, rf_rd, rf_value, st_commit, st_index, flush,
             redirect_pc, commit_cnt} != '0) begin
            fails++;
            $display("FAIL %s: pop=%0b rfv=%0b st=%0b fl=%0b pc=%h cnt=%0d, required all zero",
                     name, pop, rf_valid, st_commit, flush, redirect_pc, commit_cnt);
        end
    endtask

    // Monitor: compare each pulse cycle against the queued event for that cycle.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pop || rf_valid || st_commit || flush) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event cyc=%0d: pop=%0b rfv=%0b st=%0b fl=%0b, required none",
                             cyc, pop, rf_valid, st_commit, flush);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (cyc == e.cyc) && (pop == e.pop) && (rf_valid == e.rfv) &&
                         (st_commit == e.st) && (flush == e.fl) && (commit_cnt == e.cnt) &&
                         (!e.rfv || (rf_index == e.idx && rf_rd == e.rd && rf_value == e.val)) &&
                         (!e.st  || st_index == e.idx) &&
                         (!e.fl  || redirect_pc == e.pc);
                    if (!ok) begin
                        fails++;
                        $display("FAIL event cyc=%0d: got pop=%0b rfv=%0b st=%0b fl=%0b idx=%0d/%0d rd=%0d val=%h pc=%h cnt=%0d; required cyc=%0d pop=%0b rfv=%0b st=%0b fl=%0b idx=%0d rd=%0d val=%h pc=%h cnt=%0d",
                                 cyc, pop, rf_valid, st_commit, flush, rf_index, st_index, rf_rd,
                                 rf_value, redirect_pc, commit_cnt, e.cyc, e.pop, e.rfv, e.st,
                                 e.fl, e.idx, e.rd, e.val, e.pc, e.cnt);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_event cyc=%0d: got no pulse, required pop=%0b st=%0b fl=%0b at cyc %0d",
                         cyc, exp_q[0].pop, exp_q[0].st, exp_q[0].fl, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_vec(input vec_t v);
        head_valid = 1'b1; head_ready = 1'b1; head_type = v.t; head_rd = v.rd;
        head_value = v.val; head_index = v.idx; head_mispredict = v.mis; head_target = v.tgt;
        exp_cnt++;
        push_ev(cyc + 1, 1'b1, v.exp_rfv, 1'b0, 1'b0, v.idx, v.rd, v.val, 32'd0, exp_cnt);
        if (v.exp_flush)
            push_ev(cyc + 2, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 32'd0, v.tgt, exp_cnt);
        tick;
        head_valid = 1'b0; head_mispredict = 1'b0;
        tick;
        if (v.exp_flush) tick;
    endtask

    vec_t vecs[6];

    initial begin
        rst = 1'b1; rdy = 1'b1; head_valid = 1'b0; head_ready = 1'b0; head_mispredict = 1'b0;
        st_done = 1'b0; head_index = '0; head_type = '0; head_rd = '0; head_value = '0;
        head_target = '0;
        tick; tick;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check_zero("reset_idle");
        end

        // Two back-to-back ready ALU heads: pops two cycles apart; second has rd=0.
        head_valid = 1'b1; head_ready = 1'b1; head_type = 2'b00; head_rd = 5'd5;
        head_value = 32'h1234; head_index = 6'd3;
        push_ev(cyc + 1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd3, 5'd5, 32'h1234, 32'd0, 32'd1);
        push_ev(cyc + 3, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, 5'd0, 32'h1234, 32'd0, 32'd2);
        exp_cnt = 32'd2;
        tick;
        head_rd = 5'd0;
        tick; tick;
        head_valid = 1'b0;
        tick;

        // Store at index 7: st_done withheld for 4 cycles, then pop one cycle after it.
        head_valid = 1'b1; head_ready = 1'b1; head_type = 2'b01; head_index = 6'd7;
        push_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd7, 5'd0, 32'd0, 32'd0, exp_cnt);
        tick;
        head_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        st_done = 1'b1;
        exp_cnt++;
        push_ev(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 32'd0, 32'd0, exp_cnt);
        tick;
        st_done = 1'b0;
        tick;

        // type, rd, value, index, mispredict, target, expected rf_valid, expected flush
        vecs[0] = '{2'b11, 5'd1,  32'h0000_0044, 6'd9,  1'b1, 32'h0000_0080, 1'b1, 1'b1};
        vecs[1] = '{2'b10, 5'd0,  32'h0000_0000, 6'd11, 1'b1, 32'h0000_0200, 1'b0, 1'b1};
        vecs[2] = '{2'b10, 5'd0,  32'h0000_0000, 6'd12, 1'b0, 32'h0000_0300, 1'b0, 1'b0};
        vecs[3] = '{2'b00, 5'd3,  32'h0000_0055, 6'd10, 1'b1, 32'h0000_0999, 1'b1, 1'b0};
        vecs[4] = '{2'b11, 5'd31, 32'hdead_beef, 6'd63, 1'b0, 32'h0000_0400, 1'b1, 1'b0};
        vecs[5] = '{2'b11, 5'd0,  32'h0000_0007, 6'd0,  1'b1, 32'hffff_fffc, 1'b0, 1'b1};
        foreach (vecs[i]) run_vec(vecs[i]);

        // rdy low in IDLE with a ready head: nothing retires until rdy returns.
        rdy = 1'b0;
        head_valid = 1'b1; head_ready = 1'b1; head_type = 2'b00; head_rd = 5'd2;
        head_value = 32'habc; head_index = 6'd4;
        tick; tick;
        rdy = 1'b1;
        exp_cnt++;
        push_ev(cyc + 1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd4, 5'd2, 32'habc, 32'd0, exp_cnt);
        tick;
        // rdy low in COMMIT: pop and rf write held, count frozen, for 3 more cycles.
        rdy = 1'b0; head_valid = 1'b0;
        for (int i = 1; i <= 3; i++)
            push_ev(cyc + i, 1'b1, 1'b1, 1'b0, 1'b0, 6'd4, 5'd2, 32'habc, 32'd0, exp_cnt);
        tick; tick; tick;
        rdy = 1'b1;
        tick;

        // Head not ready: held in IDLE.
        head_valid = 1'b1; head_ready = 1'b0; head_type = 2'b00;
        tick; tick;
        head_valid = 1'b0;

        // Reset while waiting on a store: abandon it and clear everything.
        head_valid = 1'b1; head_ready = 1'b1; head_type = 2'b01; head_index = 6'd12;
        push_ev(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd12, 5'd0, 32'd0, 32'd0, exp_cnt);
        tick;
        head_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_cnt = 32'd0;
        check_zero("reset_in_wait_st");
        // st_done outside WAIT_ST must be ignored.
        st_done = 1'b1;
        tick; tick;
        st_done = 1'b0;
        run_vec('{2'b00, 5'd8, 32'h0bad_cafe, 6'd21, 1'b0, 32'd0, 1'b1, 1'b0});

        tick; tick;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d events outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
